// File: rtl/fix_session_manager.sv
// FIX session-layer controller: turns parsed message type/validity into one-cycle
// action strobes for a single session, tracking logon, resend and logout phases.
//
// state       | meaning
// IDLE        | no transport connection, waiting for connected_i
// LOGON_WAIT  | Logon sent, waiting for the peer's Logon
// ACTIVE      | session up, normal message flow
// RESEND      | gap detected, waiting for the resend to finish
// LOGOUT_WAIT | Logout sent, waiting for the peer's Logout or a timeout
module fix_session_manager #(
    parameter int                  HOST_W         = 10,
    parameter int                  COMPID_W       = 256,
    parameter logic [COMPID_W-1:0] TARGET_COMP_ID = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_message_i,
    input  logic [2:0]          validity_i,
    input  logic                timeout_i,
    input  logic [HOST_W-1:0]   connected_host_i,
    input  logic [2:0]          type_i,
    input  logic                connected_i,
    input  logic                end_session_i,
    input  logic                resendDone_i,
    output logic                ignore_o,
    output logic                igonre_o,
    output logic                disconnect_o,
    output logic [2:0]          error_type_o,
    output logic                resendReq_o,
    output logic [COMPID_W-1:0] targetCompId_o,
    output logic                doResend_o,
    output logic                sendHeartbeat_o,
    output logic                sendLogout_o,
    output logic                sendLogon_o,
    output logic                messagereceived_o,
    output logic                updateSeqCounter_o,
    output logic [HOST_W-1:0]   seqCounterLoc_o,
    output logic [HOST_W-1:0]   disconnect_host_num_o,
    output logic                end_session_o
);

    typedef enum logic [2:0] {IDLE, LOGON_WAIT, ACTIVE, RESEND, LOGOUT_WAIT} state_t;

    state_t state;
    logic   msg_seen;
    logic   drop;
    logic   msg_ok;

    assign msg_ok = (validity_i == 3'd0);

    // Every path that tears the session down, gathered so the teardown is applied once.
    always_comb begin
        drop = 1'b0;
        case (state)
            LOGON_WAIT:
                drop = new_message_i ? !(msg_ok && type_i == 3'd0) : timeout_i;
            ACTIVE, RESEND:
                drop = !end_session_i && new_message_i &&
                       (validity_i == 3'd2 || (msg_ok && type_i == 3'd0));
            LOGOUT_WAIT:
                drop = new_message_i ? (msg_ok && type_i == 3'd4) : timeout_i;
            default:
                drop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            msg_seen              <= 1'b0;
            ignore_o              <= 1'b0;
            igonre_o              <= 1'b0;
            disconnect_o          <= 1'b0;
            error_type_o          <= 3'd0;
            resendReq_o           <= 1'b0;
            targetCompId_o        <= '0;
            doResend_o            <= 1'b0;
            sendHeartbeat_o       <= 1'b0;
            sendLogout_o          <= 1'b0;
            sendLogon_o           <= 1'b0;
            messagereceived_o     <= 1'b0;
            updateSeqCounter_o    <= 1'b0;
            seqCounterLoc_o       <= '0;
            disconnect_host_num_o <= '0;
            end_session_o         <= 1'b0;
        end else begin
            ignore_o           <= 1'b0;
            igonre_o           <= 1'b0;
            disconnect_o       <= 1'b0;
            resendReq_o        <= 1'b0;
            doResend_o         <= 1'b0;
            sendHeartbeat_o    <= 1'b0;
            sendLogout_o       <= 1'b0;
            sendLogon_o        <= 1'b0;
            messagereceived_o  <= 1'b0;
            updateSeqCounter_o <= 1'b0;
            end_session_o      <= 1'b0;

            case (state)
                IDLE: begin
                    if (connected_i) begin
                        seqCounterLoc_o <= connected_host_i;
                        error_type_o    <= 3'd0;
                        sendLogon_o     <= 1'b1;
                        state           <= LOGON_WAIT;
                    end
                end
                LOGON_WAIT: begin
                    if (new_message_i) begin
                        if (msg_ok && type_i == 3'd0) begin
                            messagereceived_o  <= 1'b1;
                            updateSeqCounter_o <= 1'b1;
                            targetCompId_o     <= TARGET_COMP_ID;
                            state              <= ACTIVE;
                        end else begin
                            error_type_o <= 3'd5;
                        end
                    end else if (timeout_i) begin
                        error_type_o <= 3'd3;
                    end
                end
                ACTIVE, RESEND: begin
                    if (end_session_i) begin
                        sendLogout_o <= 1'b1;
                        state        <= LOGOUT_WAIT;
                    end else begin
                        // Message handling below may override this return to ACTIVE.
                        if (state == RESEND && resendDone_i)
                            state <= ACTIVE;
                        if (new_message_i) begin
                            if (validity_i == 3'd2) begin
                                error_type_o <= 3'd1;
                            end else if (validity_i == 3'd4) begin
                                error_type_o <= 3'd2;
                                sendLogout_o <= 1'b1;
                                state        <= LOGOUT_WAIT;
                            end else if (validity_i == 3'd1) begin
                                if (state == ACTIVE) begin
                                    resendReq_o       <= 1'b1;
                                    messagereceived_o <= 1'b1;
                                    state             <= RESEND;
                                end
                            end else if (!msg_ok) begin
                                ignore_o <= 1'b1;
                                igonre_o <= 1'b1;
                            end else begin
                                messagereceived_o  <= 1'b1;
                                updateSeqCounter_o <= 1'b1;
                                msg_seen           <= 1'b1;
                                case (type_i)
                                    3'd0: error_type_o <= 3'd6;
                                    3'd2: sendHeartbeat_o <= 1'b1;
                                    3'd3: begin
                                        if (state == ACTIVE) begin
                                            doResend_o <= 1'b1;
                                            state      <= RESEND;
                                        end
                                    end
                                    3'd4: begin
                                        sendLogout_o <= 1'b1;
                                        state        <= LOGOUT_WAIT;
                                    end
                                    default: ;
                                endcase
                            end
                        end else if (state == ACTIVE && timeout_i) begin
                            if (msg_seen) begin
                                sendHeartbeat_o <= 1'b1;
                                msg_seen        <= 1'b0;
                            end else begin
                                error_type_o <= 3'd4;
                                sendLogout_o <= 1'b1;
                                state        <= LOGOUT_WAIT;
                            end
                        end
                    end
                end
                LOGOUT_WAIT: begin
                    if (new_message_i) begin
                        if (msg_ok && type_i == 3'd4) begin
                            messagereceived_o <= 1'b1;
                        end else begin
                            ignore_o <= 1'b1;
                            igonre_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (drop) begin
                disconnect_o          <= 1'b1;
                end_session_o         <= 1'b1;
                disconnect_host_num_o <= seqCounterLoc_o;
                targetCompId_o        <= '0;
                state                 <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fix_session_manager.sv
// Bench for fix_session_manager: a directed vector table for the session scenarios,
// then random traffic checked against a rule-level session model.
module tb_fix_session_manager;

    localparam logic [255:0] TCID = 256'h1234_5678_9ABC_DEF0_0000_1111_2222_3333_4444_5555_6666_7777_CAFE_F00D_DEAD_BEEF;

    // Strobe vector bit layout
    localparam logic [9:0] IGN = 10'b1000000000;
    localparam logic [9:0] DIS = 10'b0100000000;
    localparam logic [9:0] RRQ = 10'b0010000000;
    localparam logic [9:0] DRS = 10'b0001000000;
    localparam logic [9:0] HB  = 10'b0000100000;
    localparam logic [9:0] LGO = 10'b0000010000;
    localparam logic [9:0] LGN = 10'b0000001000;
    localparam logic [9:0] MR  = 10'b0000000100;
    localparam logic [9:0] UPD = 10'b0000000010;
    localparam logic [9:0] ENDS = 10'b0000000001;

    logic         clk = 1'b0;
    logic         rst, new_message, timeout, connected, end_session, resend_done;
    logic [2:0]   validity, msg_type;
    logic [9:0]   host;
    logic         ignore, igonre, disconnect, resend_req, do_resend, send_hb, send_logout, send_logon;
    logic         msg_rcv, upd_seq, end_sess;
    logic [2:0]   error_type;
    logic [255:0] target_comp_id;
    logic [9:0]   seq_loc, disc_host;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fix_session_manager #(.HOST_W(10), .COMPID_W(256), .TARGET_COMP_ID(TCID)) dut (
        .clk(clk), .rst(rst), .new_message_i(new_message), .validity_i(validity),
        .timeout_i(timeout), .connected_host_i(host), .type_i(msg_type),
        .connected_i(connected), .end_session_i(end_session), .resendDone_i(resend_done),
        .ignore_o(ignore), .igonre_o(igonre), .disconnect_o(disconnect),
        .error_type_o(error_type), .resendReq_o(resend_req), .targetCompId_o(target_comp_id),
        .doResend_o(do_resend), .sendHeartbeat_o(send_hb), .sendLogout_o(send_logout),
        .sendLogon_o(send_logon), .messagereceived_o(msg_rcv), .updateSeqCounter_o(upd_seq),
        .seqCounterLoc_o(seq_loc), .disconnect_host_num_o(disc_host), .end_session_o(end_sess)
    );

    logic [9:0] act_s;
    assign act_s = {ignore, disconnect, resend_req, do_resend, send_hb, send_logout,
                    send_logon, msg_rcv, upd_seq, end_sess};

    typedef struct {
        logic       rst, conn;
        logic [9:0] host;
        logic       nm;
        logic [2:0] val, typ;
        logic       to, es, rd;
        logic [9:0] s;
        logic [2:0] err;
        logic [9:0] loc, dh;
        logic       cid;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic [9:0] h, input logic n,
                                input logic [2:0] va, input logic [2:0] ty, input logic t,
                                input logic e, input logic d, input logic [9:0] s,
                                input logic [2:0] er, input logic [9:0] lo, input logic [9:0] dh,
                                input logic ci);
        vec_t x;
        x.rst = r; x.conn = c; x.host = h; x.nm = n; x.val = va; x.typ = ty;
        x.to = t; x.es = e; x.rd = d; x.s = s; x.err = er; x.loc = lo; x.dh = dh; x.cid = ci;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        rst = x.rst; connected = x.conn; host = x.host; new_message = x.nm;
        validity = x.val; msg_type = x.typ; timeout = x.to; end_session = x.es; resend_done = x.rd;
    endtask

    task automatic chk(input string name, input int cyc, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    task automatic chk_all(input int cyc, input logic [9:0] s, input logic [2:0] err,
                           input logic [9:0] loc, input logic [9:0] dh, input logic cid);
        chk("strobes", cyc, 256'(act_s), 256'(s));
        chk("igonre", cyc, 256'(igonre), 256'(s[9]));
        chk("error_type", cyc, 256'(error_type), 256'(err));
        chk("seq_loc", cyc, 256'(seq_loc), 256'(loc));
        chk("disc_host", cyc, 256'(disc_host), 256'(dh));
        chk("comp_id", cyc, target_comp_id, cid ? TCID : 256'h0);
    endtask

    // Session model: phases by name, decisions straight from the session rules.
    typedef enum int {P_DOWN, P_LOGON, P_UP, P_RESENDING, P_CLOSING} phase_t;
    phase_t     m_phase;
    logic       m_seen, m_cid;
    logic [2:0] m_err;
    logic [9:0] m_loc, m_dh, m_s;

    task automatic model_step(input vec_t x);
        bit     teardown;
        phase_t start;
        bit     valid;
        teardown = 0;
        m_s = '0;
        start = m_phase;
        valid = (x.val == 0);
        if (x.rst) begin
            m_phase = P_DOWN; m_seen = 0; m_err = 0; m_loc = 0; m_dh = 0; m_cid = 0;
            return;
        end
        if (start == P_DOWN) begin
            if (x.conn) begin
                m_loc = x.host; m_err = 0; m_s = LGN; m_phase = P_LOGON;
            end
        end else if (start == P_LOGON) begin
            if (x.nm && valid && x.typ == 0) begin
                m_s = MR | UPD; m_cid = 1; m_phase = P_UP;
            end else if (x.nm) begin
                m_err = 5; teardown = 1;
            end else if (x.to) begin
                m_err = 3; teardown = 1;
            end
        end else if (start == P_CLOSING) begin
            if (x.nm && valid && x.typ == 4) begin
                m_s = MR; teardown = 1;
            end else if (x.nm) begin
                m_s = IGN;
            end else if (x.to) begin
                teardown = 1;
            end
        end else if (x.es) begin
            m_s = LGO; m_phase = P_CLOSING;
        end else begin
            if (x.nm) begin
                case (x.val)
                    3'd0: begin
                        m_s = MR | UPD; m_seen = 1;
                        if (x.typ == 2) m_s |= HB;
                        if (x.typ == 3 && start == P_UP) begin m_s |= DRS; m_phase = P_RESENDING; end
                        if (x.typ == 4) begin m_s |= LGO; m_phase = P_CLOSING; end
                        if (x.typ == 0) begin m_err = 6; teardown = 1; end
                    end
                    3'd1: if (start == P_UP) begin m_s = RRQ | MR; m_phase = P_RESENDING; end
                    3'd2: begin m_err = 1; teardown = 1; end
                    3'd4: begin m_err = 2; m_s = LGO; m_phase = P_CLOSING; end
                    default: m_s = IGN;
                endcase
            end else if (start == P_UP && x.to) begin
                if (m_seen) begin
                    m_s = HB; m_seen = 0;
                end else begin
                    m_err = 4; m_s = LGO; m_phase = P_CLOSING;
                end
            end
            if (start == P_RESENDING && x.rd && m_phase == P_RESENDING && !teardown)
                m_phase = P_UP;
        end
        if (teardown) begin
            m_s |= DIS | ENDS; m_dh = m_loc; m_cid = 0; m_phase = P_DOWN;
        end
    endtask

    vec_t vecs[$];

    initial begin
        vec_t x;
        // rst conn host nm val typ to es rd | strobes err loc dh cid
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,        0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,        0,0,0,0));
        vecs.push_back(mk(0,1,5,0,0,0,0,0,0, LGN,      0,5,0,0));
        vecs.push_back(mk(0,0,5,0,0,0,0,0,0, 0,        0,5,0,0));
        vecs.push_back(mk(0,0,5,1,0,0,0,0,0, MR|UPD,   0,5,0,1));
        vecs.push_back(mk(0,0,5,1,0,2,0,0,0, MR|UPD|HB,0,5,0,1));
        vecs.push_back(mk(0,0,5,1,1,6,0,0,0, RRQ|MR,   0,5,0,1));
        vecs.push_back(mk(0,0,5,1,0,3,0,0,0, MR|UPD,   0,5,0,1));
        vecs.push_back(mk(0,0,5,0,0,0,0,0,1, 0,        0,5,0,1));
        vecs.push_back(mk(0,0,5,1,0,3,0,0,0, MR|UPD|DRS,0,5,0,1));
        vecs.push_back(mk(0,0,5,0,0,0,0,0,1, 0,        0,5,0,1));
        vecs.push_back(mk(0,0,5,1,2,6,0,0,0, DIS|ENDS, 1,5,5,0));
        vecs.push_back(mk(0,1,7,0,0,0,0,0,0, LGN,      0,7,5,0));
        vecs.push_back(mk(0,0,7,1,0,0,0,0,0, MR|UPD,   0,7,5,1));
        vecs.push_back(mk(0,0,7,1,0,1,0,0,0, MR|UPD,   0,7,5,1));
        vecs.push_back(mk(0,0,7,0,0,0,1,0,0, HB,       0,7,5,1));
        vecs.push_back(mk(0,0,7,0,0,0,1,0,0, LGO,      4,7,5,1));
        vecs.push_back(mk(0,0,7,1,0,1,0,0,0, IGN,      4,7,5,1));
        vecs.push_back(mk(0,0,7,1,0,4,0,0,0, MR|DIS|ENDS,4,7,7,0));
        vecs.push_back(mk(0,1,3,0,0,0,0,0,0, LGN,      0,3,7,0));
        vecs.push_back(mk(0,0,3,1,0,0,0,0,0, MR|UPD,   0,3,7,1));
        vecs.push_back(mk(0,0,3,1,5,2,0,0,0, IGN,      0,3,7,1));
        vecs.push_back(mk(0,0,3,1,0,2,0,1,0, LGO,      0,3,7,1));
        vecs.push_back(mk(1,0,3,0,0,0,0,0,0, 0,        0,0,0,0));
        vecs.push_back(mk(0,1,2,0,0,0,0,0,0, LGN,      0,2,0,0));
        vecs.push_back(mk(0,0,2,0,0,0,1,0,0, DIS|ENDS, 3,2,2,0));
        vecs.push_back(mk(0,1,2,0,0,0,0,0,0, LGN,      0,2,2,0));
        vecs.push_back(mk(0,0,2,1,0,1,0,0,0, DIS|ENDS, 5,2,2,0));
        vecs.push_back(mk(0,1,2,0,0,0,0,0,0, LGN,      0,2,2,0));
        vecs.push_back(mk(0,0,2,1,0,0,0,0,0, MR|UPD,   0,2,2,1));
        vecs.push_back(mk(0,0,2,1,4,6,0,0,0, LGO,      2,2,2,1));
        vecs.push_back(mk(0,0,2,0,0,0,1,0,0, DIS|ENDS, 2,2,2,0));
        vecs.push_back(mk(0,1,9,0,0,0,0,0,0, LGN,      0,9,2,0));
        vecs.push_back(mk(0,0,9,1,0,0,0,0,0, MR|UPD,   0,9,2,1));
        vecs.push_back(mk(0,0,9,1,0,0,0,0,0, MR|UPD|DIS|ENDS,6,9,9,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].s, vecs[i].err, vecs[i].loc, vecs[i].dh, vecs[i].cid);
        end

        // Random traffic against the session model, starting from a reset.
        for (int i = 0; i < 4000; i++) begin
            x.rst  = (i == 0) || ($urandom_range(0, 199) == 0);
            x.conn = ($urandom_range(0, 7) == 0);
            x.host = 10'($urandom_range(0, 1023));
            x.nm   = ($urandom_range(0, 2) == 0);
            x.val  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            x.typ  = 3'($urandom_range(0, 7));
            x.to   = ($urandom_range(0, 9) == 0);
            x.es   = ($urandom_range(0, 29) == 0);
            x.rd   = ($urandom_range(0, 7) == 0);
            x.s = '0; x.err = '0; x.loc = '0; x.dh = '0; x.cid = 1'b0;
            drive(x);
            model_step(x);
            @(posedge clk);
            #1;
            chk_all(1000 + i, m_s, m_err, m_loc, m_dh, m_cid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fix_session_manager.md
Name: fix_session_manager

Overview:
FIX-protocol session-layer controller for one active session at a time, located between the message parser/validator and the outbound message generator. It takes decoded message type and validity flags and drives one-cycle action strobes: logon, heartbeat, logout, resend, ignore, disconnect and sequence-counter update. It also reports error codes and the host being serviced.

Parameters:
HOST_W, 10, width of host index (connected_host_i, seqCounterLoc_o, disconnect_host_num_o)
COMPID_W, 256, width of targetCompId_o
TARGET_COMP_ID, 256'h0, CompID value presented on targetCompId_o while a session is up

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
new_message_i  in  1  one-cycle strobe: type_i/validity_i valid
validity_i  in  3  0 ok, 1 seq too high, 2 seq too low, 3 garbled, 4 bad CompID, 5 bad checksum, 6-7 garbled
timeout_i  in  1  heartbeat-interval expiry strobe
connected_host_i  in  HOST_W  host index of current transport connection
type_i  in  3  0 Logon, 1 Heartbeat, 2 TestRequest, 3 ResendRequest, 4 Logout, 5 SequenceReset, 6 Application, 7 Reject
connected_i  in  1  strobe: transport connection established
end_session_i  in  1  strobe: local request to end session
resendDone_i  in  1  strobe: outbound resend finished
ignore_o, igonre_o  out  1  discard current message (identical copies)
disconnect_o  out  1  drop transport connection
error_type_o  out  3  last error code, held
resendReq_o  out  1  send ResendRequest
targetCompId_o  out  COMPID_W  CompID of current session
doResend_o  out  1  start resending outbound messages
sendHeartbeat_o, sendLogout_o, sendLogon_o  out  1  send that message
messagereceived_o  out  1  message accepted
updateSeqCounter_o  out  1  increment inbound seq counter at seqCounterLoc_o
seqCounterLoc_o  out  HOST_W  latched session host index
disconnect_host_num_o  out  HOST_W  host being disconnected
end_session_o  out  1  session fully closed

Behaviour:
- All outputs are registered. Strobe outputs pulse high for exactly one cycle, the cycle after the triggering input edge.
- Reset: state IDLE. All strobes 0, error_type_o 0, targetCompId_o 0, seqCounterLoc_o 0, disconnect_host_num_o 0, msg_seen flag 0. Reset mid-session aborts without any strobe.
- States: IDLE, LOGON_WAIT, ACTIVE, RESEND, LOGOUT_WAIT.
- IDLE: connected_i latches connected_host_i into seqCounterLoc_o, clears error_type_o, pulses sendLogon_o, and moves to LOGON_WAIT. All other inputs are ignored.
- LOGON_WAIT:
  - new_message_i, validity 0, type 0: pulse messagereceived_o and updateSeqCounter_o, load TARGET_COMP_ID into targetCompId_o, go to ACTIVE.
  - Any other message: error 5, DISCONNECT action.
  - timeout_i: error 3, DISCONNECT action.
- ACTIVE, one new_message_i handled per cycle, checked in this order:
  - validity 2: error 1, DISCONNECT.
  - validity 4: error 2, pulse sendLogout_o, go to LOGOUT_WAIT.
  - validity 3, 5, 6 or 7: ignore_o/igonre_o pulse, no counter update.
  - validity 1: resendReq_o and messagereceived_o pulse, go to RESEND.
  - validity 0: messagereceived_o and updateSeqCounter_o pulse, set msg_seen. Then by type: 1 no extra action; 2 sendHeartbeat_o; 3 doResend_o and go to RESEND; 4 sendLogout_o and go to LOGOUT_WAIT; 0 error 6 and DISCONNECT; 5, 6 or 7 no extra action.
- timeout_i in ACTIVE: if msg_seen, pulse sendHeartbeat_o and clear msg_seen; else error 4, sendLogout_o, go to LOGOUT_WAIT.
- end_session_i in ACTIVE or RESEND: sendLogout_o, go to LOGOUT_WAIT. It has priority over a same-cycle new_message_i, which is ignored and gets no strobe.
- RESEND: messages are processed as in ACTIVE, except a second gap (validity 1) is ignored. resendDone_i returns to ACTIVE; if it coincides with a message, the message is processed first and the same cycle returns to ACTIVE.
- LOGOUT_WAIT: valid type-4 message (messagereceived_o) or timeout_i triggers DISCONNECT; other messages pulse ignore_o.
- DISCONNECT action: pulse disconnect_o and end_session_o, load seqCounterLoc_o into disconnect_host_num_o, clear targetCompId_o, go to IDLE.
- error_type_o holds until the next error or the next connected_i.
- connected_i outside IDLE is ignored.
- Priority within a cycle: rst > end_session_i > new_message_i > resendDone_i > timeout_i.

Test Plan:
- rst=1 for 2 cycles, then connected_i=1 for 1 cycle with connected_host_i=5 -> sendLogon_o=1 next cycle only, seqCounterLoc_o=5, all other strobes 0.
- From LOGON_WAIT: new_message_i with type 0, validity 0 -> messagereceived_o=1, updateSeqCounter_o=1, targetCompId_o=TARGET_COMP_ID. Then type 2 -> sendHeartbeat_o=1.
- ACTIVE, validity 1 -> resendReq_o=1. Next, type 3 validity 0 -> no doResend_o (still RESEND). resendDone_i -> ACTIVE; type 3 validity 0 -> doResend_o=1.
- ACTIVE, validity 2 with host 5 -> disconnect_o=1, end_session_o=1, disconnect_host_num_o=5, error_type_o=1. Then connected_i -> error_type_o=0, sendLogon_o=1.
- ACTIVE, two timeout_i with no message between -> first sendHeartbeat_o=1, second sendLogout_o=1 and error_type_o=4. Then type 4 validity 0 -> disconnect_o=1.
- ACTIVE, end_session_i and new_message_i in the same cycle -> only sendLogout_o=1. Assert rst the next cycle -> all outputs 0, IDLE.
